// File: rtl/video_capture.sv
// rtl/video_capture.sv - crops a window out of an RGB pixel stream into 16-pixel grayscale BRAM words
// Armed capture of one frame; sticky status for done and stream framing errors.
module video_capture #(
  parameter int X_SIZE    = 640,
  parameter int Y_SIZE    = 480,
  parameter int CROP_X0   = 306,
  parameter int CROP_Y0   = 226,
  parameter int CROP_SIZE = 28,
  parameter int BASE_ADDR = 0
) (
  input  logic         in_stream_aclk,
  input  logic         periph_reset,
  input  logic [31:0]  in_stream_tdata,
  input  logic [3:0]   in_stream_tkeep,
  input  logic         in_stream_tuser,
  input  logic         in_stream_tlast,
  input  logic         in_stream_tvalid,
  output logic         in_stream_tready,
  input  logic         arm,
  output logic         busy,
  output logic         capture_done,
  output logic         sof_err,
  output logic         eol_err,
  output logic [11:0]  bram_addr,
  output logic [255:0] bram_wrdata,
  output logic [31:0]  bram_we,
  output logic         bram_en
);
  localparam int XW = $clog2(X_SIZE + 1);
  localparam int YW = $clog2(Y_SIZE + 1);
  localparam logic [XW-1:0] X_LAST = XW'(X_SIZE - 1);
  localparam logic [XW-1:0] X_END  = XW'(X_SIZE);
  localparam logic [YW-1:0] Y_END  = YW'(Y_SIZE);
  localparam logic [XW-1:0] CX_LO  = XW'(CROP_X0);
  localparam logic [XW-1:0] CX_HI  = XW'(CROP_X0 + CROP_SIZE);
  localparam logic [XW-1:0] C_LAST = XW'(CROP_SIZE - 1);
  localparam logic [YW-1:0] CY_LO  = YW'(CROP_Y0);
  localparam logic [YW-1:0] CY_HI  = YW'(CROP_Y0 + CROP_SIZE);
  localparam logic [YW-1:0] R_LAST = YW'(CROP_SIZE - 1);
  localparam logic [11:0]   BASE   = 12'(BASE_ADDR);

  typedef enum logic [1:0] {IDLE, WAIT_SOF, CAPTURE, DONE} state_t;

  state_t           state;
  logic [XW-1:0]    x, x_n, pos_x, col;
  logic [YW-1:0]    y, y_n, pos_y, row;
  logic [15:0][7:0] gray_buf, buf_n;
  logic [9:0]       sum;
  logic [7:0]       gray;
  logic [255:0]     word_n;
  logic [11:0]      addr_n;
  logic             accept, frame_start, in_crop, capturing, pack;
  logic             write_now, final_write, final_pend;
  logic             unused_bits;

  assign unused_bits = ^{in_stream_tkeep, in_stream_tdata[31:24]};

  always_comb begin
    accept      = in_stream_tvalid && in_stream_tready;
    pos_x       = in_stream_tuser ? '0 : x;
    pos_y       = in_stream_tuser ? '0 : y;
    // A frame boundary is either the reset position or the saturated end of the previous frame.
    frame_start = (x == '0) && ((y == '0) || (y == Y_END));
    sum         = {2'b00, in_stream_tdata[23:16]} + {1'b0, in_stream_tdata[15:8], 1'b0}
                + {2'b00, in_stream_tdata[7:0]};
    gray        = sum[9:2];
    col         = pos_x - CX_LO;
    row         = pos_y - CY_LO;
    in_crop     = (pos_x >= CX_LO) && (pos_x < CX_HI) && (pos_y >= CY_LO) && (pos_y < CY_HI);
    if (arm || state == WAIT_SOF) capturing = in_stream_tuser;
    else                          capturing = (state == CAPTURE) && !final_pend;
    pack        = accept && capturing && in_crop;
    write_now   = pack && ((col[3:0] == 4'hF) || (col == C_LAST));
    final_write = write_now && (col == C_LAST) && (row == R_LAST);
    // Lane 0 of each half-row starts a fresh word so unused upper lanes read back as zero.
    buf_n            = (col[3:0] == 4'h0) ? '0 : gray_buf;
    buf_n[col[3:0]]  = gray;
    for (int k = 0; k < 16; k++) word_n[16*k +: 16] = {8'h00, buf_n[k]};
    addr_n      = BASE + 12'({row, col[4]});
    x_n = x;
    y_n = y;
    if (accept) begin
      if (in_stream_tlast) begin
        x_n = '0;
        y_n = (pos_y >= Y_END) ? Y_END : pos_y + 1'b1;
      end else begin
        x_n = (pos_x >= X_END) ? X_END : pos_x + 1'b1;
        y_n = pos_y;
      end
    end
  end

  always_ff @(posedge in_stream_aclk) begin
    if (periph_reset) begin
      state            <= IDLE;
      x                <= '0;
      y                <= '0;
      gray_buf         <= '0;
      final_pend       <= 1'b0;
      in_stream_tready <= 1'b0;
      busy             <= 1'b0;
      capture_done     <= 1'b0;
      sof_err          <= 1'b0;
      eol_err          <= 1'b0;
      bram_we          <= '0;
      bram_en          <= 1'b0;
      bram_addr        <= BASE;
      bram_wrdata      <= '0;
    end else begin
      in_stream_tready <= 1'b1;
      x                <= x_n;
      y                <= y_n;
      if (pack) gray_buf <= buf_n;
      bram_we          <= {32{write_now}};
      bram_en          <= write_now;
      if (write_now) begin
        bram_addr   <= addr_n;
        bram_wrdata <= word_n;
      end
      final_pend <= final_write;
      sof_err    <= (sof_err && !arm) || (accept && in_stream_tuser && !frame_start);
      eol_err    <= (eol_err && !arm) || (accept && in_stream_tlast && (pos_x != X_LAST));
      if (arm) begin
        state        <= (accept && in_stream_tuser) ? CAPTURE : WAIT_SOF;
        busy         <= 1'b1;
        capture_done <= 1'b0;
      end else begin
        case (state)
          WAIT_SOF: if (accept && in_stream_tuser) state <= CAPTURE;
          CAPTURE: if (final_pend) begin
            state        <= DONE;
            busy         <= 1'b0;
            capture_done <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end
endmodule
